// File: rtl/simd_cell.sv
// ---------------------------------------------------------------------------
// simd_cell -- DIM_A-lane unsigned multiplier using temporal (unary-weight)
// accumulation.
//
// A pass is P = 2^WEIGHT_WIDTH enabled cycles long. On the first edge of a
// pass, each lane latches its input and weight. On each of the following
// edges, the lane adds its latched input once more while the pass index is
// below the weight. A lane therefore sums its input exactly `weight` times.
// On the last edge of the pass, the finished sums are copied to the output
// register. The output register holds that value until the next pass
// completes.
//
// Ports
//   clk              in   sole clock, rising edge
//   rst              in   asynchronous active-high reset, clears all state
//   enable           in   1 = advance the pass, 0 = freeze every register
//   input_bin        in   [DIM_A-1:0][INPUT_WIDTH-1:0]   unsigned inputs
//   weight_bin       in   [DIM_C-1:0][WEIGHT_WIDTH-1:0]  unsigned weights
//   accumulated_mult out  [DIM_MULT-1:0][ACC_WIDTH-1:0]  registered products
// ---------------------------------------------------------------------------
module simd_cell #(
  parameter int DIM_A        = 9,
  parameter int DIM_C        = 9,
  parameter int DIM_MULT     = 9,
  parameter int INPUT_WIDTH  = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACC_WIDTH    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [DIM_A-1:0][INPUT_WIDTH-1:0]    input_bin,
  input  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]   weight_bin,
  output logic [DIM_MULT-1:0][ACC_WIDTH-1:0]   accumulated_mult
);

  // The lane loops index all three lane arrays with the same index.
  if (DIM_C != DIM_A || DIM_MULT != DIM_A) begin : g_bad_dims
    $error("simd_cell: DIM_C and DIM_MULT must equal DIM_A");
  end

  // Lane term on a non-start edge: the latched input while k < weight.
  function automatic logic [ACC_WIDTH-1:0] lane_term(
    input logic [INPUT_WIDTH-1:0]  in_v,
    input logic [WEIGHT_WIDTH-1:0] w_v,
    input logic [WEIGHT_WIDTH-1:0] k
  );
    return (k < w_v) ? ACC_WIDTH'(in_v) : '0;
  endfunction

  // Lane value on the pass-start edge. It uses the live inputs because the
  // lane registers are only loaded on this same edge.
  function automatic logic [ACC_WIDTH-1:0] lane_start(
    input logic [INPUT_WIDTH-1:0]  in_v,
    input logic [WEIGHT_WIDTH-1:0] w_v
  );
    return (w_v != '0) ? ACC_WIDTH'(in_v) : '0;
  endfunction

  logic [WEIGHT_WIDTH-1:0]             r_cnt;
  logic [DIM_A-1:0][INPUT_WIDTH-1:0]   r_in;
  logic [DIM_A-1:0][WEIGHT_WIDTH-1:0]  r_w;
  logic [DIM_A-1:0][ACC_WIDTH-1:0]     r_acc;
  logic [DIM_A-1:0][ACC_WIDTH-1:0]     r_out;

  logic                                w_start;
  logic                                w_last;
  logic [DIM_A-1:0][ACC_WIDTH-1:0]     w_acc_nxt;

  assign w_start = (r_cnt == '0);
  assign w_last  = (r_cnt == '1);

  // Next accumulator value for every lane. The wrap modulo 2^ACC_WIDTH is
  // intentional.
  always_comb begin
    w_acc_nxt = '0;
    for (int i = 0; i < DIM_A; i++) begin
      if (w_start) begin
        w_acc_nxt[i] = lane_start(input_bin[i], weight_bin[i]);
      end else begin
        w_acc_nxt[i] = r_acc[i] + lane_term(r_in[i], r_w[i], r_cnt);
      end
    end
  end

  // Counter, lane registers and accumulators. Everything freezes when
  // enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_in  <= '0;
      r_w   <= '0;
      r_acc <= '0;
      r_out <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + 1'b1;  // natural wrap P-1 -> 0
      if (w_start) begin
        r_in <= input_bin;
        r_w  <= weight_bin;
      end
      r_acc <= w_acc_nxt;
      // The final edge of the pass publishes the sum including this edge's term.
      if (w_last) begin
        r_out <= w_acc_nxt;
      end
    end
  end

  assign accumulated_mult = r_out;

endmodule

// File: tb/tb_simd_cell.sv
module tb_simd_cell;

  localparam int N  = 9;
  localparam int IW = 4;
  localparam int WW = 4;
  localparam int AW = 8;
  localparam int P  = 1 << WW;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   enable = 1'b0;
  logic [N-1:0][IW-1:0]   input_bin = '0;
  logic [N-1:0][WW-1:0]   weight_bin = '0;
  logic [N-1:0][AW-1:0]   accumulated_mult;

  int total = 0;
  int bad   = 0;

  // Behavioural model: the number of enabled edges into the current pass,
  // the operands captured at pass start, and the published products.
  int                     m_edges = 0;
  int                     m_in [N];
  int                     m_w  [N];
  logic [N-1:0][AW-1:0]   m_out = '0;

  simd_cell #(
    .DIM_A(N), .DIM_C(N), .DIM_MULT(N),
    .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .input_bin(input_bin),
    .weight_bin(weight_bin),
    .accumulated_mult(accumulated_mult)
  );

  always #5 clk = ~clk;

  // One rising edge. The model follows it, then the task returns 1 time
  // unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst && enable) begin
      if (m_edges == 0) begin
        for (int i = 0; i < N; i++) begin
          m_in[i] = int'(input_bin[i]);
          m_w[i]  = int'(weight_bin[i]);
        end
      end
      m_edges++;
      if (m_edges == P) begin
        m_edges = 0;
        for (int i = 0; i < N; i++) m_out[i] = AW'((m_in[i] * m_w[i]) % (1 << AW));
      end
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) tick();
  endtask

  task automatic check(input string tag, input logic [N-1:0][AW-1:0] exp);
    total++;
    assert (accumulated_mult === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h expected=%h", tag, accumulated_mult, exp);
    end
  endtask

  // Pulse reset between edges. The output must clear without a clock edge.
  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    m_edges = 0;
    m_out   = '0;
    check(tag, '0);
    rst = 1'b0;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++) begin
      input_bin[i]  = IW'($urandom_range(0, (1 << IW) - 1));
      weight_bin[i] = WW'($urandom_range(0, (1 << WW) - 1));
    end
  endtask

  logic [N-1:0][AW-1:0] exp_sq;
  logic [N-1:0][AW-1:0] exp_ext;
  logic [N-1:0][AW-1:0] held;

  initial begin
    // Reset state, then idle with enable low.
    #1;
    check("reset_state", '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      input_bin[i]  = 4'd9;
      weight_bin[i] = 4'd9;
    end
    ticks(20);
    check("idle_after_reset", '0);
    ticks(20);
    check("idle_long", '0);

    // Squares pattern {0,1,...,8}, MSB lane first.
    for (int i = 0; i < N; i++) begin
      input_bin[i]  = IW'(N - 1 - i);
      weight_bin[i] = WW'(N - 1 - i);
      exp_sq[i]     = AW'((N - 1 - i) * (N - 1 - i));
    end
    enable = 1'b1;
    ticks(P - 1);
    check("squares_not_early", '0);
    tick();
    check("squares_model", m_out);
    check("squares_const", exp_sq);

    // Extremes: inputs 15, weights alternate 15/0.
    for (int i = 0; i < N; i++) begin
      input_bin[i]  = 4'd15;
      weight_bin[i] = (i % 2 == 0) ? 4'd15 : 4'd0;
      exp_ext[i]    = (i % 2 == 0) ? 8'd225 : 8'd0;
    end
    ticks(P - 1);
    check("squares_held", exp_sq);
    tick();
    check("extremes", exp_ext);

    // Pause for 5 cycles mid-pass.
    randomize_inputs();
    ticks(8);
    held = accumulated_mult;
    enable = 1'b0;
    randomize_inputs();
    ticks(5);
    check("pause_frozen", exp_ext);
    enable = 1'b1;
    ticks(P - 8 - 1);
    check("pause_not_early", exp_ext);
    tick();
    check("pause_result", m_out);

    // Change the operands at cnt=8. The current pass must keep the old
    // values, and the next pass must take the new ones.
    randomize_inputs();
    ticks(8);
    randomize_inputs();
    ticks(P - 8);
    check("midchange_old", m_out);
    ticks(P);
    check("midchange_new", m_out);

    // Asynchronous reset at cnt=10, then a clean full pass.
    randomize_inputs();
    ticks(10);
    pulse_reset("async_reset_mid");
    ticks(P - 1);
    check("post_reset_not_early", '0);
    tick();
    check("post_reset_pass", m_out);

    // Random operands, enable pattern and occasional resets, checked every
    // cycle against the model.
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) randomize_inputs();
      tick();
      check("random", m_out);
      if ($urandom_range(0, 99) == 0) pulse_reset("random_reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
